axi4lite_register_slave: RTL and testbench
==========================================

# axi4lite_register_slave

AXI4-Lite slave register bank that sits directly downstream of the PicoBlaze AXI4-Lite master bridge. It terminates the single-outstanding read and write transactions issued by that bridge. It stores C_NUM_REGS 32-bit registers with byte-strobe writes, exports their contents and per-register write pulses to fabric logic, and returns OKAY or SLVERR responses.

## Interface
- C_ADDRESS_WIDTH, 32: AXI address width; only bits [2+:log2(C_NUM_REGS)] and the range check above them are decoded.
- C_DATA_WIDTH, 32: data width; only 32 is supported.
- C_NUM_REGS, 16: number of registers; power of two, 2..256.
- s_axi_aclk  in  1  single clock.
- s_axi_aresetn  in  1  reset; asynchronous, active-low.
- s_axi_awaddr  in  C_ADDRESS_WIDTH  write address.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  C_ADDRESS_WIDTH  read address.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- reg_out  out  32*C_NUM_REGS  flat register contents; register k is at [32k+:32].
- reg_wstb  out  C_NUM_REGS  one-cycle pulse on the cycle after register k is written.

## Operation
- Reset (asynchronous, while s_axi_aresetn=0): all outputs are 0, including every ready, valid, resp, rdata, reg_out and reg_wstb. All readies rise on the first clock edge after deassertion.
- Write path: AW and W are accepted independently and in either order.
  - awready=1 while no address is held; wready=1 while no data is held; neither is asserted while bvalid=1.
  - When both address and data are held, the write commits on the next edge. Each byte lane i with wstrb[i]=1 is written, bvalid is set, and the held flags clear.
  - bvalid stays high until the bvalid&bready edge, after which awready and wready return to 1.
- Read path: arready=1 while rvalid=0.
  - On the AR handshake, rdata is loaded from the addressed register and rvalid is set on the same edge.
  - rvalid and rdata are held until rready.
- Decode: index = addr[2+:log2(C_NUM_REGS)]. Address bits [1:0] are ignored. The address is out-of-range if any bit above the index field is set.
- Out-of-range behaviour depends on the configuration (see Configuration).
- The read and write paths are fully independent. A read and a write commit to the same register on the same edge return the old value.

## Timing
- Write latency: bvalid is high in the cycle after the later of the AW and W handshakes. reg_out updates on that same edge; reg_wstb pulses one cycle later, for exactly one cycle.
- Read latency: rvalid is high in the cycle after the AR handshake.
- Throughput: one write per 2 cycles and one read per 2 cycles when bready and rready are held at 1.
- Back-pressure: if bready or rready is low, the corresponding channel stalls with no loss of data.
- A reset asserted mid-transaction drops any held AW/W/B/R state and clears all registers; no response is issued afterwards.

## Configuration
- AXI4LITE_REGISTER_SLAVE_SLVERR_EN defined: out-of-range writes change no register and no reg_wstb bit, with bresp=2'b10. Out-of-range reads return rdata=0 and rresp=2'b10.
- Macro undefined: out-of-range accesses alias to the decoded index and return OKAY. This keeps address decoding minimal when the block owns the whole aperture.

## Structure
- The shared package/header defines RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, the word-address LSB constant (2), and a clog2 function.
- One sub-module: axi4lite_aw_w_join. It holds the AW and W skid registers and produces a single "commit" strobe with the latched address, data and strobe. It is reused by other slaves.

## Test plan
- Post-reset: all readies=0 while reset is asserted and 1 one cycle after release; reg_out=0.
- AW and W in the same cycle: addr 0x08, wdata 0xDEADBEEF, wstrb 0xF -> bvalid next cycle with bresp=OKAY, reg_out[64+:32]=0xDEADBEEF, reg_wstb[2] pulses once.
- W three cycles before AW, wstrb 0x2, wdata 0x0000AB00, to register 2 holding 0xDEADBEEF -> register becomes 0xDEADABEF; wready is low between the two handshakes.
- Read 0x08 with rready held low for 5 cycles -> rvalid and rdata=0xDEADABEF stable throughout, arready=0 until the R handshake.
- With SLVERR_EN defined and C_NUM_REGS=16, write and read 0x40 -> bresp=rresp=2'b10, rdata=0, no reg_wstb. With the macro undefined -> aliases to register 0 with OKAY.
- Reset asserted while bvalid=1 and bready=0 -> bvalid=0 immediately, and no B beat after release.

Source files
------------

// File: rtl/axi4lite_register_slave_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// word-address LSB and an elaboration-time clog2 helper.
package axi4lite_register_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Registers are 32-bit words, so byte-address bits [1:0] are ignored.
  localparam int WORD_ADDR_LSB = 2;

  // Ceiling log2, usable in localparam expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi4lite_aw_w_join.sv
// AW/W join: accepts the write-address and write-data channels independently
// and in either order, and emits a single commit strobe together with the
// merged address, data and strobe. The commit fires on the edge where the
// second of the two beats is accepted (or both arrive together), so the
// downstream response can be valid in the very next cycle.
module axi4lite_aw_w_join #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  b_busy,
  output logic                  commit,
  output logic [ADDR_W-1:0]     commit_addr,
  output logic [DATA_W-1:0]     commit_data,
  output logic [DATA_W/8-1:0]   commit_strb
);

  logic                en_q;
  logic                aw_held;
  logic                w_held;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W/8-1:0] strb_q;
  logic                aw_hs;
  logic                w_hs;

  // Readies are gated by en_q so they stay low in reset and rise on the
  // first edge after release; both drop while a response is outstanding.
  assign awready = en_q & ~aw_held & ~b_busy;
  assign wready  = en_q & ~w_held  & ~b_busy;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid  & wready;

  // A write is complete once both halves are either held or arriving now.
  assign commit      = (aw_held | aw_hs) & (w_held | w_hs);
  assign commit_addr = aw_held ? addr_q : awaddr;
  assign commit_data = w_held  ? data_q : wdata;
  assign commit_strb = w_held  ? strb_q : wstrb;

  // Skid registers for whichever channel arrives first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q    <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, so the order of statements in this block does not matter.
      en_q <= 1'b1;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          addr_q  <= awaddr;
        end
        if (w_hs) begin
          w_held <= 1'b1;
          data_q <= wdata;
          strb_q <= wstrb;
        end
      end
    end
  end

endmodule

// File: rtl/axi4lite_register_slave.sv
// AXI4-Lite register bank of C_NUM_REGS 32-bit registers with byte-strobe
// writes, flat register export and per-register write pulses.
// Optional feature macro: AXI4LITE_REGISTER_SLAVE_SLVERR_EN -- when defined,
// accesses above the decoded index field return SLVERR, writes are dropped
// and reads return zero; otherwise they alias onto the decoded index.
module axi4lite_register_slave
  import axi4lite_register_slave_pkg::*;
#(
  parameter int C_ADDRESS_WIDTH = 32,
  parameter int C_DATA_WIDTH    = 32,
  parameter int C_NUM_REGS      = 16
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic [C_ADDRESS_WIDTH-1:0]       s_axi_awaddr,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [C_ADDRESS_WIDTH-1:0]       s_axi_araddr,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  output logic [C_DATA_WIDTH*C_NUM_REGS-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]            reg_wstb
);

  localparam int IDX_W  = clog2(C_NUM_REGS);
  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int HI_LSB = WORD_ADDR_LSB + IDX_W;

`ifdef AXI4LITE_REGISTER_SLAVE_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic [C_DATA_WIDTH-1:0]    regs [C_NUM_REGS];
  logic [C_NUM_REGS-1:0]      wstb_pend;

  logic                       commit;
  logic [C_ADDRESS_WIDTH-1:0] cm_addr;
  logic [C_DATA_WIDTH-1:0]    cm_data;
  logic [STRB_W-1:0]          cm_strb;

  logic [IDX_W-1:0]           wr_idx;
  logic                       wr_err;
  logic [IDX_W-1:0]           rd_idx;
  logic                       rd_err;
  logic                       ar_hs;
  logic                       rd_en_q;
  logic [C_DATA_WIDTH-1:0]    rd_data_next;
  logic [1:0]                 rd_resp_next;

  axi4lite_aw_w_join #(
    .ADDR_W (C_ADDRESS_WIDTH),
    .DATA_W (C_DATA_WIDTH)
  ) u_join (
    .aclk        (s_axi_aclk),
    .aresetn     (s_axi_aresetn),
    .awaddr      (s_axi_awaddr),
    .awvalid     (s_axi_awvalid),
    .awready     (s_axi_awready),
    .wdata       (s_axi_wdata),
    .wstrb       (s_axi_wstrb),
    .wvalid      (s_axi_wvalid),
    .wready      (s_axi_wready),
    .b_busy      (s_axi_bvalid),
    .commit      (commit),
    .commit_addr (cm_addr),
    .commit_data (cm_data),
    .commit_strb (cm_strb)
  );

  // Address decode: index field plus "any bit above it set" range check.
  assign wr_idx = cm_addr[WORD_ADDR_LSB +: IDX_W];
  assign wr_err = SLVERR_EN && ((cm_addr >> HI_LSB) != '0);
  assign rd_idx = s_axi_araddr[WORD_ADDR_LSB +: IDX_W];
  assign rd_err = SLVERR_EN && ((s_axi_araddr >> HI_LSB) != '0);

  assign s_axi_arready = rd_en_q & ~s_axi_rvalid;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;

  // Flat export of the register bank.
  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
    assign reg_out[C_DATA_WIDTH*k +: C_DATA_WIDTH] = regs[k];
  end

  // Write commit: byte-lane update, B response and delayed write pulse.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      // NOTE: the register bank is reset explicitly because a reset must
      // clear every register; it is flops, not a RAM, so this is legal.
      for (int k = 0; k < C_NUM_REGS; k++) regs[k] <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      wstb_pend    <= '0;
      reg_wstb     <= '0;
    end else begin
      reg_wstb  <= wstb_pend;
      wstb_pend <= '0;
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (!wr_err) begin
          for (int i = 0; i < STRB_W; i++) begin
            if (cm_strb[i]) regs[wr_idx][8*i +: 8] <= cm_data[8*i +: 8];
          end
          wstb_pend[wr_idx] <= 1'b1;
        end
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read-data selection for the AR handshake.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch.
    rd_data_next = regs[rd_idx];
    rd_resp_next = RESP_OKAY;
    if (rd_err) begin
      rd_data_next = '0;
      rd_resp_next = RESP_SLVERR;
    end
  end

  // Read channel: load on AR handshake, hold until R handshake.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_en_q      <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else begin
      rd_en_q <= 1'b1;
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data_next;
        s_axi_rresp  <= rd_resp_next;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_register_slave.sv
// Directed self-checking bench for axi4lite_register_slave (C_NUM_REGS=16).
// Expected out-of-range results follow AXI4LITE_REGISTER_SLAVE_SLVERR_EN.
module tb_axi4lite_register_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr, wdata, araddr;
  logic [3:0]   wstrb;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [511:0] reg_out;
  logic [15:0]  reg_wstb;

  int checks = 0;
  int errors = 0;

`ifdef AXI4LITE_REGISTER_SLAVE_SLVERR_EN
  localparam bit OOR_ERR = 1'b1;
`else
  localparam bit OOR_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  axi4lite_register_slave #(
    .C_ADDRESS_WIDTH (32),
    .C_DATA_WIDTH    (32),
    .C_NUM_REGS      (16)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .reg_out       (reg_out),
    .reg_wstb      (reg_wstb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_word(input int k);
    return reg_out[32*k +: 32];
  endfunction

  initial begin
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;

    // Reset state
    #2;
    check("rst_ready", {29'b0, awready, wready, arready}, 32'h0);
    check("rst_valid", {30'b0, bvalid, rvalid}, 32'h0);
    check("rst_regout", {31'b0, |reg_out}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    tick(); tick();
    check("rst_hold_ready", {29'b0, awready, wready, arready}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {29'b0, awready, wready, arready}, 32'h7);
    check("post_rst_wstb", {16'b0, reg_wstb}, 32'h0);

    // AW and W together to register 2
    awaddr = 32'h08; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    check("wr1_bvalid", {31'b0, bvalid}, 32'h1);
    check("wr1_bresp", {30'b0, bresp}, 32'h0);
    check("wr1_reg2", reg_word(2), 32'hDEADBEEF);
    check("wr1_wstb_early", {16'b0, reg_wstb}, 32'h0);
    check("wr1_ready_blocked", {30'b0, awready, wready}, 32'h0);
    tick();
    check("wr1_wstb_pulse", {16'b0, reg_wstb}, 32'h4);
    check("wr1_bvalid_hold", {31'b0, bvalid}, 32'h1);
    bready = 1;
    tick();
    check("wr1_bdone", {31'b0, bvalid}, 32'h0);
    check("wr1_wstb_once", {16'b0, reg_wstb}, 32'h0);
    check("wr1_ready_back", {30'b0, awready, wready}, 32'h3);
    bready = 0;

    // W three cycles before AW, single byte lane 1
    wdata = 32'h0000AB00; wstrb = 4'h2; wvalid = 1;
    tick();
    wvalid = 0;
    check("wr2_wready_low0", {31'b0, wready}, 32'h0);
    check("wr2_awready_hi", {31'b0, awready}, 32'h1);
    check("wr2_no_b", {31'b0, bvalid}, 32'h0);
    tick();
    check("wr2_wready_low1", {31'b0, wready}, 32'h0);
    tick();
    check("wr2_wready_low2", {31'b0, wready}, 32'h0);
    awaddr = 32'h08; awvalid = 1;
    tick();
    awvalid = 0;
    check("wr2_bvalid", {31'b0, bvalid}, 32'h1);
    check("wr2_reg2", reg_word(2), 32'hDEADABEF);
    bready = 1;
    tick();
    check("wr2_bdone", {31'b0, bvalid}, 32'h0);
    bready = 0;

    // Read register 2 with rready held low for 5 cycles
    araddr = 32'h08; arvalid = 1;
    tick();
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rd1_rvalid_%0d", i), {31'b0, rvalid}, 32'h1);
      check($sformatf("rd1_rdata_%0d", i), rdata, 32'hDEADABEF);
      check($sformatf("rd1_arready_%0d", i), {31'b0, arready}, 32'h0);
      tick();
    end
    check("rd1_rresp", {30'b0, rresp}, 32'h0);
    rready = 1;
    tick();
    check("rd1_rdone", {31'b0, rvalid}, 32'h0);
    check("rd1_arready_back", {31'b0, arready}, 32'h1);
    rready = 0;

    // AW one cycle before W, register 15, lanes 0 and 3, bready held high
    bready = 1;
    awaddr = 32'h3C; awvalid = 1;
    tick();
    awvalid = 0;
    check("wr3_awready_low", {31'b0, awready}, 32'h0);
    check("wr3_wready_hi", {31'b0, wready}, 32'h1);
    wdata = 32'hAABBCCDD; wstrb = 4'b1001; wvalid = 1;
    tick();
    wvalid = 0;
    check("wr3_bvalid", {31'b0, bvalid}, 32'h1);
    check("wr3_reg15", reg_word(15), 32'hAA0000DD);
    tick();
    check("wr3_bdone", {31'b0, bvalid}, 32'h0);
    check("wr3_wstb", {16'b0, reg_wstb}, 32'h8000);

    // Same-edge read and write of register 15 returns the old value
    awaddr = 32'h3C; awvalid = 1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1;
    araddr = 32'h3C; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("rw_old_rdata", rdata, 32'hAA0000DD);
    check("rw_new_reg15", reg_word(15), 32'h11111111);
    rready = 1;
    tick();
    rready = 0;
    bready = 0;

    // Out-of-range write and read at 0x40
    awaddr = 32'h40; awvalid = 1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    check("oor_bresp", {30'b0, bresp}, OOR_ERR ? 32'h2 : 32'h0);
    check("oor_reg0", reg_word(0), OOR_ERR ? 32'h0 : 32'h12345678);
    check("oor_reg2_kept", reg_word(2), 32'hDEADABEF);
    tick();
    check("oor_wstb", {16'b0, reg_wstb}, OOR_ERR ? 32'h0 : 32'h1);
    bready = 1;
    tick();
    bready = 0;
    araddr = 32'h40; arvalid = 1;
    tick();
    arvalid = 0;
    check("oor_rvalid", {31'b0, rvalid}, 32'h1);
    check("oor_rdata", rdata, OOR_ERR ? 32'h0 : 32'h12345678);
    check("oor_rresp", {30'b0, rresp}, OOR_ERR ? 32'h2 : 32'h0);
    rready = 1;
    tick();
    rready = 0;

    // Reset while a B beat is stalled
    awaddr = 32'h04; awvalid = 1; wdata = 32'h00000005; wstrb = 4'hF; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    check("mid_bvalid", {31'b0, bvalid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", {31'b0, bvalid}, 32'h0);
    check("mid_rst_regout", {31'b0, |reg_out}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    bready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_no_b_%0d", i), {31'b0, bvalid}, 32'h0);
    end
    check("mid_ready_back", {29'b0, awready, wready, arready}, 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
